// File: rtl/kanagawa_fifo_drain_arbiter.sv
// Round-robin drain of NUM_QUEUES show-ahead FIFOs into one registered valid/ready stage.
// A burst limit bounds starvation; queue_mask parks queues at runtime.
module kanagawa_fifo_drain_arbiter #(
    parameter int unsigned NUM_QUEUES = 4,
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned MAX_BURST  = 4,
    parameter int unsigned ID_WIDTH   = $clog2(NUM_QUEUES),
    parameter int unsigned CNT_WIDTH  = $clog2(MAX_BURST + 1)
) (
    input  logic                        clock,
    input  logic                        rst,
    input  logic [NUM_QUEUES-1:0]       fifo_empty,
    input  logic [NUM_QUEUES*WIDTH-1:0] fifo_q,
    output logic [NUM_QUEUES-1:0]       fifo_rdreq,
    input  logic [NUM_QUEUES-1:0]       queue_mask,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WIDTH-1:0]            out_data,
    output logic [ID_WIDTH-1:0]         out_queue_id,
    output logic                        busy
);

    logic [ID_WIDTH-1:0]   last_q_q,       last_q_d;
    logic [CNT_WIDTH-1:0]  burst_cnt_q,    burst_cnt_d;
    logic                  out_valid_q,    out_valid_d;
    logic [WIDTH-1:0]      out_data_q,     out_data_d;
    logic [ID_WIDTH-1:0]   out_queue_id_q, out_queue_id_d;

    logic [NUM_QUEUES-1:0] eligible_c;
    logic                  load_en_c;
    logic                  hold_c;
    logic                  any_sel_c;
    logic                  pop_c;
    logic [ID_WIDTH-1:0]   sel_c;
    int unsigned           idx_c;

    // Grant selection: stay on the current queue while its burst lasts, else scan from last_q+1.
    always_comb begin
        eligible_c = queue_mask & ~fifo_empty;
        load_en_c  = ~out_valid_q | out_ready;
        hold_c     = (burst_cnt_q != '0) && (burst_cnt_q < CNT_WIDTH'(MAX_BURST))
                     && eligible_c[last_q_q];
        sel_c      = last_q_q;
        any_sel_c  = hold_c;
        idx_c      = 0;
        if (!hold_c) begin
            for (int unsigned k = 1; k <= NUM_QUEUES; k++) begin
                idx_c = 32'(last_q_q) + k;
                if (idx_c >= NUM_QUEUES) begin
                    idx_c = idx_c - NUM_QUEUES;
                end
                if (!any_sel_c && eligible_c[idx_c[ID_WIDTH-1:0]]) begin
                    sel_c     = idx_c[ID_WIDTH-1:0];
                    any_sel_c = 1'b1;
                end
            end
        end
        pop_c      = load_en_c & any_sel_c & ~rst;
        fifo_rdreq = '0;
        if (pop_c) begin
            fifo_rdreq[sel_c] = 1'b1;
        end
    end

    always_comb begin
        last_q_d       = last_q_q;
        burst_cnt_d    = burst_cnt_q;
        out_valid_d    = out_valid_q;
        out_data_d     = out_data_q;
        out_queue_id_d = out_queue_id_q;
        if (pop_c) begin
            out_data_d     = fifo_q[32'(sel_c)*WIDTH +: WIDTH];
            out_queue_id_d = sel_c;
            out_valid_d    = 1'b1;
            last_q_d       = sel_c;
            burst_cnt_d    = hold_c ? (burst_cnt_q + CNT_WIDTH'(1)) : CNT_WIDTH'(1);
        end else if (load_en_c) begin
            // Nothing to pop: the output empties but arbitration history is kept.
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            last_q_q       <= ID_WIDTH'(NUM_QUEUES - 1);
            burst_cnt_q    <= '0;
            out_valid_q    <= 1'b0;
            out_data_q     <= '0;
            out_queue_id_q <= '0;
        end else begin
            last_q_q       <= last_q_d;
            burst_cnt_q    <= burst_cnt_d;
            out_valid_q    <= out_valid_d;
            out_data_q     <= out_data_d;
            out_queue_id_q <= out_queue_id_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_queue_id = out_queue_id_q;
    assign busy         = out_valid_q | (|eligible_c);

endmodule
